// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8-bit UART transmitter, 8N1/8N2, optional parity bit via UART_TX_PARITY_EN
module uart_tx_unit #(
    parameter int clk_freq   = 12_000_000,
    parameter int baud       = 115200,
    parameter int stop_bits  = 1,
    parameter int parity_odd = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);
    localparam int CLKS_PER_BIT = clk_freq / baud;
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    if (stop_bits < 1 || stop_bits > 2 || parity_odd < 0 || parity_odd > 1 || CLKS_PER_BIT < 2)
    begin : g_bad_cfg
        $error("uart_tx_unit: illegal parameter set");
    end
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;
    state_t state, state_n;
    logic [CW-1:0] baud_cnt, baud_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shift_reg, shift_n;
    logic tx_n, busy_n, done_n, wrap;
`ifdef UART_TX_PARITY_EN
    logic par, par_n;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            tx        <= tx_n;
            tx_busy   <= busy_n;
            tx_done   <= done_n;
`ifdef UART_TX_PARITY_EN
            par       <= par_n;
`endif
        end
    end
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        tx_n    = tx;
        busy_n  = tx_busy;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        wrap    = baud_cnt == CW'(CLKS_PER_BIT - 1);
        baud_n  = state == S_IDLE ? '0 : wrap ? '0 : baud_cnt + CW'(1);
        case (state)
            S_IDLE: if (tx_start) begin
                state_n = S_START;
                shift_n = tx_data;
                tx_n    = 1'b0;
                busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
                par_n   = (^tx_data) ^ 1'(parity_odd);
`endif
            end
            S_START: if (wrap) begin
                state_n = S_DATA;
                bit_n   = '0;
                tx_n    = shift_reg[0];
            end
            S_DATA: if (wrap) begin
                if (bit_cnt == 3'd7) begin
                    bit_n = '0;
`ifdef UART_TX_PARITY_EN
                    state_n = S_PARITY;
                    tx_n    = par;
`else
                    state_n = S_STOP;
                    tx_n    = 1'b1;
`endif
                end else begin
                    bit_n   = bit_cnt + 3'd1;
                    shift_n = shift_reg >> 1;
                    tx_n    = shift_reg[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (wrap) begin
                state_n = S_STOP;
                bit_n   = '0;
                tx_n    = 1'b1;
            end
`endif
            S_STOP: if (wrap) begin
                // bit_cnt counts stop bits already completed
                if (bit_cnt == 3'(stop_bits - 1)) begin
                    state_n = S_IDLE;
                    bit_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    bit_n = bit_cnt + 3'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: frame-level model of uart_tx_unit checked every cycle, plus directed literals
module tb_uart_tx_unit;
    localparam int N = 104;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam int SB = 2;
    localparam int LEN_LIT = 1248;
    localparam logic [11:0] F55_LIT = 12'hCAA;
`else
    localparam int P = 0;
    localparam int SB = 1;
    localparam int LEN_LIT = 1040;
    localparam logic [11:0] F55_LIT = 12'hEAA;
`endif
    localparam int FLEN = (10 + P + SB - 1) * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_busy, tx_done, tx;

    uart_tx_unit #(.clk_freq(12_000_000), .baud(115200), .stop_bits(SB), .parity_odd(0)) dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // whole frame as a bit vector: index 0 is the start bit, then data LSB first, parity, stops
    function automatic logic [11:0] frame(input logic [7:0] d);
        frame = '1;
        frame[0] = 1'b0;
        frame[8:1] = d;
`ifdef UART_TX_PARITY_EN
        frame[9] = ^d;
`endif
    endfunction

    logic m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0, armed = 1'b0;
    int pos = 0;
    logic [11:0] fbits = '1;
    logic [7:0] acc_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_tx <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0; armed <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                pos <= pos + 1;
                if (pos + 1 == FLEN) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_tx <= 1'b1;
                end else
                    m_tx <= fbits[(pos + 1) / N];
            end else if (tx_start) begin
                fbits <= frame(tx_data);
                pos <= 0;
                m_busy <= 1'b1;
                m_tx <= 1'b0;
                acc_q.push_back(tx_data);
            end
        end
    end

    int busy_len = 0, idle_len = 0, last_len = 0, last_gap = 0, done_cnt = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (armed) begin
            chk("tx", tx, m_tx);
            chk("tx_busy", tx_busy, m_busy);
            chk("tx_done", tx_done, m_done);
        end
        if (tx_busy === 1'b1) begin
            busy_len <= busy_len + 1;
            idle_len <= 0;
            if (!prev_busy) last_gap <= idle_len;
        end else begin
            idle_len <= idle_len + 1;
            busy_len <= 0;
            if (prev_busy) last_len <= busy_len;
        end
        prev_busy <= tx_busy === 1'b1;
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data = ~b;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 3000, 1);
    endtask

    initial begin
        int d0, q0, seen, n;
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", tx, 1);
            chk("rst_busy", tx_busy, 0);
            chk("rst_done", tx_done, 0);
        end
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_tx", tx, 1);
        chk("post_rst_busy", tx_busy, 0);

        chk("frame55", frame(8'h55), F55_LIT);
        d0 = done_cnt; q0 = acc_q.size();
        send(8'h55);
        wait_idle();
        tick(2);
        chk("t2_len", last_len, LEN_LIT);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_acc", acc_q.size() - q0, 1);
        chk("t2_byte", acc_q[q0], 8'h55);

        q0 = acc_q.size();
        send(8'h41);
        chk("t3_busy_poll", tx_busy, 1);
        wait_idle();
        send(8'h0A);
        wait_idle();
        tick(2);
        chk("t3_acc", acc_q.size() - q0, 2);
        chk("t3_b0", acc_q[q0], 8'h41);
        chk("t3_b1", acc_q[q0+1], 8'h0A);

        q0 = acc_q.size(); d0 = done_cnt;
        send(8'h00);
        tick(199);
        send(8'hFF);
        wait_idle();
        tick(2);
        chk("t4_acc", acc_q.size() - q0, 1);
        chk("t4_byte", acc_q[q0], 8'h00);
        chk("t4_done", done_cnt - d0, 1);

        send(8'hA5);
        tick(499);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_tx", tx, 1);
        chk("t5_busy", tx_busy, 0);
        chk("t5_done", tx_done, 0);
        rst_n = 1'b1;
        q0 = acc_q.size();
        send(8'h3C);
        wait_idle();
        tick(2);
        chk("t5_len", last_len, FLEN);
        chk("t5_byte", acc_q[q0], 8'h3C);

        chk("frame07", frame(8'h07), 12'hE0E);
        q0 = acc_q.size();
        @(negedge clk);
        tx_start = 1'b1;
        tx_data = 8'h07;
        seen = 0; n = 0;
        while (seen < 2 && n < 6000) begin
            @(negedge clk);
            if (tx_done) seen++;
            n++;
        end
        tx_start = 1'b0;
        chk("t6_timeout", seen, 2);
        tick(3);
        chk("t6_gap", last_gap, 1);
        chk("t6_len", last_len, LEN_LIT == 1248 ? 1248 : FLEN);
        chk("t6_acc", acc_q.size() - q0, 2);
        chk("t6_b1", acc_q[q0+1], 8'h07);
        chk("t6_idle", tx_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
